// File: rtl/mul_div_if.sv
// rtl/mul_div_if.sv - issue/result bundle between the EX stage and the multiply/divide unit
//
// Purpose: groups the request and result signals of mul_div_unit.
// Ports (signals):
//   start, flush, op[1:0], operand_a, operand_b   request side (driven by EX)
//   busy, done, hi, lo, div_by_zero               result side (driven by the unit)
// Modports: master = EX stage, slave = mul_div_unit.
interface mul_div_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             flush;
   logic [1:0]       op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   modport master (
      output start, flush, op, operand_a, operand_b,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, flush, op, operand_a, operand_b,
      output busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative multiply/divide unit producing hi/lo/SR for the EX stage
//
// Purpose: one-bit-per-cycle shift-add multiplier and restoring divider on
//   unsigned magnitudes, with a final sign-correction cycle.
//   op: 00 MULU, 01 MUL signed, 10 DIVU, 11 DIV signed.
//   MUL: {hi,lo} = product.  DIV: lo = quotient, hi = remainder.
// Ports:
//   clk    in  rising-edge clock
//   rest   in  asynchronous active-low reset
//   bus    mul_div_if.slave (start/flush/op/operand_a/operand_b in,
//          busy/done/hi/lo/div_by_zero out, all outputs registered)
module mul_div_unit #(
   parameter int WIDTH = 16
) (
   input logic      clk,
   input logic      rest,
   mul_div_if.slave bus
);

   localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] cntLast = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } stateType;

   stateType             state;
   logic [CntW-1:0]      counter;
   // MUL: acc = {partial product high, remaining multiplier bits}
   // DIV: acc = {partial remainder, dividend bits / quotient bits}
   logic [2*WIDTH-1:0]   acc;
   // MUL: multiplicand magnitude. DIV: divisor magnitude.
   logic [WIDTH-1:0]     opB;
   logic                 isDiv;
   logic                 negMain;   // negate product / quotient
   logic                 negRem;    // negate remainder (dividend negative)

   logic                 busyReg;
   logic                 doneReg;
   logic [WIDTH-1:0]     hiReg;
   logic [WIDTH-1:0]     loReg;
   logic                 dbzReg;

   // Request decode
   logic                 inSigned;
   logic [WIDTH-1:0]     magA;
   logic [WIDTH-1:0]     magB;

   always_comb begin
      inSigned = bus.op[0];
      magA     = (inSigned && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
      magB     = (inSigned && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;
   end

   // One iteration step
   logic [WIDTH:0]       mulSum;
   logic [2*WIDTH-1:0]   mulNext;
   logic [WIDTH:0]       divTrial;
   logic [2*WIDTH-1:0]   divNext;
   logic [2*WIDTH-1:0]   accNext;

   always_comb begin
      // Shift-add: add multiplicand into the high half when the current
      // multiplier bit is set, then shift the whole pair right by one.
      mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : '0);
      mulNext = {mulSum, acc[WIDTH-1:1]};

      // Restoring divide: shift remainder/dividend left, try subtracting the
      // divisor from the top W+1 bits; keep the difference only if no borrow.
      divTrial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opB};
      if (!divTrial[WIDTH]) begin
         divNext = {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
         divNext = {acc[2*WIDTH-2:0], 1'b0};
      end

      accNext = isDiv ? divNext : mulNext;
   end

   // Sign correction applied in FIXUP
   logic [2*WIDTH-1:0]   prodFix;
   logic [WIDTH-1:0]     quotFix;
   logic [WIDTH-1:0]     remFix;
   logic [WIDTH-1:0]     fixHi;
   logic [WIDTH-1:0]     fixLo;

   always_comb begin
      prodFix = negMain ? -acc : acc;
      quotFix = negMain ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      remFix  = negRem  ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      if (isDiv) begin
         fixHi = remFix;
         fixLo = quotFix;
      end else begin
         fixHi = prodFix[2*WIDTH-1:WIDTH];
         fixLo = prodFix[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         state   <= IDLE;
         counter <= '0;
         acc     <= '0;
         opB     <= '0;
         isDiv   <= 1'b0;
         negMain <= 1'b0;
         negRem  <= 1'b0;
         busyReg <= 1'b0;
         doneReg <= 1'b0;
         hiReg   <= '0;
         loReg   <= '0;
         dbzReg  <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start && !bus.flush) begin
                  isDiv   <= bus.op[1];
                  negMain <= inSigned & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
                  negRem  <= inSigned & bus.operand_a[WIDTH-1];
                  opB     <= bus.op[1] ? magB : magA;
                  acc     <= {{WIDTH{1'b0}}, (bus.op[1] ? magA : magB)};
                  counter <= '0;
                  busyReg <= 1'b1;
                  dbzReg  <= 1'b0;
                  if (bus.op[1] && (bus.operand_b == '0)) begin
                     // Divide by zero skips the iteration and commits at once.
                     state   <= DONE;
                     doneReg <= 1'b1;
                     loReg   <= '1;
                     hiReg   <= bus.operand_a;
                     dbzReg  <= 1'b1;
                  end else begin
                     state <= CALC;
                  end
               end
            end

            CALC: begin
               if (bus.flush) begin
                  state   <= IDLE;
                  busyReg <= 1'b0;
               end else begin
                  acc     <= accNext;
                  counter <= counter + 1'b1;
                  if (counter == cntLast) begin
                     state <= FIXUP;
                  end
               end
            end

            FIXUP: begin
               if (bus.flush) begin
                  state   <= IDLE;
                  busyReg <= 1'b0;
               end else begin
                  hiReg   <= fixHi;
                  loReg   <= fixLo;
                  doneReg <= 1'b1;
                  state   <= DONE;
               end
            end

            DONE: begin
               // Result already committed; flush has nothing left to cancel.
               state   <= IDLE;
               busyReg <= 1'b0;
            end

            default: begin
               state   <= IDLE;
               busyReg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy        = busyReg;
   assign bus.done        = doneReg;
   assign bus.hi          = hiReg;
   assign bus.lo          = loReg;
   assign bus.div_by_zero = dbzReg;

endmodule
